// File: rtl/iocap_pkg.sv
// Shared types and limits for the IOB capture scheduler.
// Build option: define IOCAP_PARK_EN to park the capture register at all-ones while idle.
package iocap_pkg;

  typedef enum logic [2:0] {
    IOCAP_IDLE    = 3'd0,
    IOCAP_SETTLE  = 3'd1,
    IOCAP_CAPTURE = 3'd2,
    IOCAP_WAIT    = 3'd3,
    IOCAP_RETURN  = 3'd4
  } iocap_state_t;

  localparam int IOCAP_MAX_NREQ   = 16;
  localparam int IOCAP_MAX_SETTLE = 255;

  // Next requester index with wrap; n need not be a power of two.
  function automatic int iocap_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/io_capture_scheduler_if.sv
// Requester, pin-mux and capture-register signals of the IOB capture scheduler.
// Build option IOCAP_PARK_EN only changes how CapSet is driven.
interface io_capture_scheduler_if #(
  parameter int width = 8,
  parameter int NREQ  = 4,
  parameter int SELW  = $clog2(NREQ)
);

  // Handshake: Req[i] is a level request held until the single-cycle Ack[i];
  // there is no back-pressure, Data is valid in the Ack cycle and held after.
  logic [NREQ-1:0]  Req;
  logic [SELW-1:0]  Sel;
  logic             CapReset;
  logic             CapSet;
  logic             CapEnable;
  logic [width-1:0] CapOut;
  logic [width-1:0] Data;
  logic [NREQ-1:0]  Ack;
  logic             Busy;

  modport master (
    input  Req, CapOut,
    output Sel, CapReset, CapSet, CapEnable, Data, Ack, Busy
  );

  modport slave (
    output Req, CapOut,
    input  Sel, CapReset, CapSet, CapEnable, Data, Ack, Busy
  );

endinterface

// File: rtl/iocap_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr, wrapping.
// Unaffected by IOCAP_PARK_EN.
module iocap_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SELW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  logic [NREQ-1:0] eligible;
  logic [SELW:0]   probe;

  assign eligible = req & ~mask;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int off = 0; off < NREQ; off++) begin
      probe = {1'b0, ptr} + (SELW+1)'(off);
      if (probe >= (SELW+1)'(NREQ)) probe = probe - (SELW+1)'(NREQ);
      if (!grant_valid && eligible[probe[SELW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = probe[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/io_capture_scheduler.sv
// Time-shares one IOB capture register among NREQ requesters through a pin mux.
// Define IOCAP_PARK_EN to hold CapSet high while idle (parks the register at all-ones).
module io_capture_scheduler
  import iocap_pkg::*;
#(
  parameter int width  = 8,
  parameter int NREQ   = 4,
  parameter int SELW   = $clog2(NREQ),
  parameter int SETTLE = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  io_capture_scheduler_if.master bus,
  output iocap_state_t           fsm_state
);

  iocap_state_t     state_q, state_d;
  logic [7:0]       cnt_q;
  logic [SELW-1:0]  sel_q;
  logic [SELW-1:0]  rr_ptr_q;
  logic [width-1:0] data_q;
  logic [NREQ-1:0]  ack_q;
  logic             busy_q;
  logic             cap_en_q;
  logic             cap_set_q;
  logic             cap_rst_q;

  logic [NREQ-1:0]  sel_onehot;
  logic [NREQ-1:0]  arb_mask;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             load_grant;

  assign sel_onehot = NREQ'(1) << sel_q;

  iocap_rr_arbiter #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_arb (
    .req         (bus.Req),
    .mask        (arb_mask),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // RETURN doubles as an arbitration slot so grants can run back-to-back;
  // the requester being acknowledged is masked so it cannot win twice in a row.
  always_comb begin
    state_d    = state_q;
    arb_mask   = '0;
    load_grant = 1'b0;
    case (state_q)
      IOCAP_IDLE: begin
        if (grant_valid) begin
          state_d    = IOCAP_SETTLE;
          load_grant = 1'b1;
        end
      end
      IOCAP_SETTLE: begin
        if (cnt_q == 8'd0) state_d = IOCAP_CAPTURE;
      end
      IOCAP_CAPTURE: state_d = IOCAP_WAIT;
      IOCAP_WAIT:    state_d = IOCAP_RETURN;
      IOCAP_RETURN: begin
        arb_mask = sel_onehot;
        if (grant_valid) begin
          state_d    = IOCAP_SETTLE;
          load_grant = 1'b1;
        end else begin
          state_d = IOCAP_IDLE;
        end
      end
      default: state_d = IOCAP_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    cap_rst_q <= Reset;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IOCAP_IDLE;
      cnt_q     <= 8'd0;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      cap_en_q  <= 1'b0;
      cap_set_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_grant) begin
        sel_q <= grant_idx;
        cnt_q <= 8'(SETTLE - 1);
      end else if (state_q == IOCAP_SETTLE && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      // Outputs are decoded from the next state so every one of them is a flop.
      cap_en_q <= (state_d == IOCAP_CAPTURE);
      busy_q   <= (state_d == IOCAP_SETTLE) || (state_d == IOCAP_CAPTURE) ||
                  (state_d == IOCAP_WAIT);
      ack_q    <= (state_d == IOCAP_RETURN) ? sel_onehot : '0;
      if (state_q == IOCAP_WAIT) data_q <= bus.CapOut;
      if (state_q == IOCAP_RETURN) rr_ptr_q <= SELW'(iocap_next_idx(int'(sel_q), NREQ));
`ifdef IOCAP_PARK_EN
      cap_set_q <= (state_d == IOCAP_IDLE);
`else
      cap_set_q <= 1'b0;
`endif
    end
  end

  assign bus.Sel       = sel_q;
  assign bus.CapReset  = cap_rst_q;
  assign bus.CapSet    = cap_set_q;
  assign bus.CapEnable = cap_en_q;
  assign bus.Data      = data_q;
  assign bus.Ack       = ack_q;
  assign bus.Busy      = busy_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_io_capture_scheduler.sv
// Directed bench for io_capture_scheduler with an IORegister model and an Ack/Data scoreboard.
// Built with IOCAP_PARK_EN it runs at SETTLE=1 and checks the CapSet parking.
module tb_io_capture_scheduler;
  import iocap_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int W     = NREQ + WIDTH;
`ifdef IOCAP_PARK_EN
  localparam int SETTLE_P = 1;
`else
  localparam int SETTLE_P = 2;
`endif
  localparam int LAT = SETTLE_P + 3;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  io_capture_scheduler_if #(.width(WIDTH), .NREQ(NREQ)) bus ();
  iocap_state_t fsm_state;

  io_capture_scheduler #(
    .width  (WIDTH),
    .NREQ   (NREQ),
    .SETTLE (SETTLE_P)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // External sources behind the pin mux, and the IORegister they feed.
  logic [WIDTH-1:0] src_val [NREQ];
  logic [WIDTH-1:0] cap_q = '0;
  always @(posedge Clock) begin
    if (bus.CapReset)       cap_q <= '0;
    else if (bus.CapSet)    cap_q <= '1;
    else if (bus.CapEnable) cap_q <= src_val[bus.Sel];
  end
  assign bus.CapOut = cap_q;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (bus.Ack !== '0) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_ack: observed ack=%b data=%h expected no ack", bus.Ack, bus.Data);
      end
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        checks++;
        assert ({bus.Ack, bus.Data} === exp_item) else begin
          errors++;
          $error("FAIL ack_data: observed ack=%b data=%h expected ack=%b data=%h",
                 bus.Ack, bus.Data, exp_item[W-1:WIDTH], exp_item[WIDTH-1:0]);
        end
      end
    end
    checks++;
    assert ((bus.CapSet && bus.CapEnable) === 1'b0) else begin
      errors++;
      $error("FAIL set_and_enable: observed both high expected not both");
    end
`ifndef IOCAP_PARK_EN
    checks++;
    assert (bus.CapSet === 1'b0) else begin
      errors++;
      $error("FAIL capset_tied: observed=%b expected=0", bus.CapSet);
    end
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic push_exp(input int idx);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    exp_q.push_back({oh, src_val[idx]});
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Ack !== '0) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL ack_timeout: observed no ack in 40 cycles expected an ack");
  endtask

  int t0, at, prev;
  int grant_seq [4];

  initial begin
    for (int i = 0; i < NREQ; i++) src_val[i] = WIDTH'($urandom_range(1, 254));
    src_val[2] = 8'hA5;
    bus.Req = '0;

    // reset values
    Reset = 1'b1;
    repeat (3) tick();
    chk("rst_sel", 32'(bus.Sel), 0);
    chk("rst_data", 32'(bus.Data), 0);
    chk("rst_ack", 32'(bus.Ack), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_capen", 32'(bus.CapEnable), 0);
    chk("rst_capset", 32'(bus.CapSet), 0);
    chk("rst_capreset", 32'(bus.CapReset), 1);
    chk("rst_state", 32'(fsm_state), 32'(IOCAP_IDLE));
    Reset = 1'b0;
    tick();
    chk("capreset_release", 32'(bus.CapReset), 0);

    // contention: all four held, grants 0,1,2,3 back-to-back
    tick();
    bus.Req = '1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) push_exp(i);
    for (int i = 0; i < 4; i++) begin
      wait_ack(at);
      if (i == 0) chk("contend_first_lat", 32'(at - t0), LAT);
      else        chk("contend_spacing", 32'(at - prev), LAT);
      prev = at;
      if (i == 3) bus.Req = '0;
    end

    // fairness: 1001 held, grants alternate 0,3,0,3
    repeat (2) tick();
    bus.Req = 4'b1001;
    grant_seq = '{0, 3, 0, 3};
    t0 = cyc;
    for (int i = 0; i < 4; i++) push_exp(grant_seq[i]);
    for (int i = 0; i < 4; i++) begin
      wait_ack(at);
      if (i == 0) chk("fair_first_lat", 32'(at - t0), LAT);
      else        chk("fair_spacing", 32'(at - prev), LAT);
      prev = at;
      if (i == 3) bus.Req = '0;
    end

    // single request to source 2, cycle-by-cycle timing
    repeat (2) tick();
    bus.Req = 4'b0100;
    push_exp(2);
`ifdef IOCAP_PARK_EN
    chk("park_idle_capset", 32'(bus.CapSet), 1);
`endif
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("single_sel", 32'(bus.Sel), 2);
      chk("single_busy", 32'(bus.Busy), (k <= SETTLE_P + 2) ? 1 : 0);
      chk("single_capen", 32'(bus.CapEnable), (k == SETTLE_P + 1) ? 1 : 0);
`ifdef IOCAP_PARK_EN
      if (k == 1) chk("park_grant_capset", 32'(bus.CapSet), 0);
`endif
      if (k == LAT) begin
        chk("single_ack", 32'(bus.Ack), 32'h4);
        chk("single_data", 32'(bus.Data), 32'hA5);
        bus.Req = '0;
      end
    end

    // dropped request: Req[1] falls in cycle 2, Ack still arrives, no regrant
    repeat (2) tick();
    bus.Req = 4'b0010;
    t0 = cyc;
    push_exp(1);
    tick();
    tick();
    bus.Req = '0;
    wait_ack(at);
    chk("drop_ack_lat", 32'(at - t0), LAT);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drop_no_regrant", 32'(bus.Busy), 0);
    end

    // reset in the CapEnable cycle aborts with no Ack
    tick();
    bus.Req = 4'b0001;
    t0 = cyc;
    at = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.CapEnable === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("abort_capen_cycle", 32'(at - t0), SETTLE_P + 1);
    Reset   = 1'b1;
    bus.Req = '0;
    tick();
    chk("abort_busy", 32'(bus.Busy), 0);
    chk("abort_sel", 32'(bus.Sel), 0);
    chk("abort_capreset", 32'(bus.CapReset), 1);
    chk("abort_ack", 32'(bus.Ack), 0);
    chk("abort_capen", 32'(bus.CapEnable), 0);
    chk("abort_state", 32'(fsm_state), 32'(IOCAP_IDLE));
    tick();
    chk("abort_capreset_hold", 32'(bus.CapReset), 1);
    Reset = 1'b0;
    tick();
    chk("abort_capreset_low", 32'(bus.CapReset), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_ack", 32'(bus.Ack), 0);
    end

    // ---------------- report ----------------
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
